// File: rtl/aes64_pkg.sv
// aes64_pkg
//   Shared definitions for the iterative AES-128 block sequencer and its
//   aes64 round-instruction datapath.
//   - seq_state_t          : sequencer FSM states
//   - AES128_ROUNDS        : number of AES-128 rounds
//   - ENC_CYCLES_PER_ROUND : datapath steps spent on each round
//   - LAST_ROUND           : round index of the final (no MixColumns) round
//   - dword_pair_t/split128: 128-bit value viewed as {hi, lo} 64-bit halves
package aes64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KS1,
    KS2A,
    KS2B,
    ENC_LO,
    ENC_HI,
    DONE
  } seq_state_t;

  localparam int AES128_ROUNDS        = 10;
  localparam int ENC_CYCLES_PER_ROUND = 5;
  localparam logic [3:0] LAST_ROUND   = 4'(AES128_ROUNDS - 1);

  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } dword_pair_t;

  // Byte lanes 0..7 form the lo half and lanes 8..15 the hi half.
  function automatic dword_pair_t split128(input logic [127:0] v);
    dword_pair_t r;
    r.hi = v[127:64];
    r.lo = v[63:0];
    return r;
  endfunction

endpackage

// File: rtl/aes64_blk_seq_aes64.sv
// aes64
//   Single-cycle, combinational aes64 round-instruction datapath.
//   Ports:
//     valid         in   operation request; ready simply mirrors it
//     op_ks1        in   key-schedule step 1 (RotWord/SubWord/Rcon on rs1[63:32],
//                        round number taken from rs2[3:0])
//     op_ks2        in   key-schedule step 2 (XOR chaining of rs1/rs2 words)
//     op_enc        in   forward round: ShiftRows/SubBytes on {rs2,rs1},
//                        returning the half selected by hi
//     op_dec        in   decrypt round select; rd reads as 0 while it is set
//     op_imix       in   inverse-mix select; rd reads as 0 while it is set
//     hi            in   op_enc: 0 = columns 0..1, 1 = columns 2..3
//     mix           in   op_enc: apply MixColumns
//     rs1, rs2      in   64-bit source operands
//     ready         out  result valid this cycle
//     rd            out  64-bit result
module aes64 (
  input  logic        valid,
  input  logic        op_ks1,
  input  logic        op_ks2,
  input  logic        op_enc,
  input  logic        op_dec,
  input  logic        op_imix,
  input  logic        hi,
  input  logic        mix,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic        ready,
  output logic [63:0] rd
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  // Round number 10 (0xA) is the "no rotate, no rcon" encoding of ks1.
  function automatic logic [7:0] rcon(input logic [3:0] rnum);
    case (rnum)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte j of the state lives at row j%4, column j/4; ShiftRows moves
  // row r left by r columns, so output byte j reads input column (col+row)%4.
  function automatic logic [63:0] enc_half(input logic [127:0] st,
                                           input logic upper,
                                           input logic do_mix);
    logic [63:0] sb;
    int j, row, col, src;
    sb = '0;
    for (int i = 0; i < 8; i++) begin
      j   = upper ? i + 8 : i;
      row = j % 4;
      col = j / 4;
      src = row + 4 * ((col + row) % 4);
      sb[8*i +: 8] = SBOX[st[8*src +: 8]];
    end
    if (do_mix) return {mix_col(sb[63:32]), mix_col(sb[31:0])};
    return sb;
  endfunction

  logic [31:0] ks1_rot;
  logic [31:0] ks1_word;
  logic [31:0] ks2_w0;
  logic [31:0] ks2_w1;

  always_comb begin
    ks1_rot = (rs2[3:0] == 4'hA) ? rs1[63:32] : {rs1[39:32], rs1[63:40]};
    ks1_word = {SBOX[ks1_rot[31:24]], SBOX[ks1_rot[23:16]],
                SBOX[ks1_rot[15:8]],  SBOX[ks1_rot[7:0]]} ^ {24'h0, rcon(rs2[3:0])};
    ks2_w0 = rs1[63:32] ^ rs2[31:0];
    ks2_w1 = ks2_w0 ^ rs2[63:32];
  end

  always_comb begin
    rd    = '0;
    ready = valid;
    if (valid && !(op_dec || op_imix)) begin
      if (op_ks1) begin
        rd = {ks1_word, ks1_word};
      end else if (op_ks2) begin
        rd = {ks2_w1, ks2_w0};
      end else if (op_enc) begin
        rd = enc_half({rs2, rs1}, hi, mix);
      end
    end
  end

endmodule

// File: rtl/aes64_blk_seq.sv
// aes64_blk_seq
//   Iterative AES-128 block encryptor built around one aes64 datapath.
//   Each round takes five steps (ks1, ks2, ks2, enc lo, enc hi) with the key
//   schedule expanded on the fly; result appears 51 cycles after acceptance.
//   Ports:
//     g_clk      in   clock, rising edge
//     g_rst      in   synchronous active-high reset
//     in_valid   in   request valid
//     in_ready   out  idle and able to accept a request
//     in_pt      in   plaintext, byte i at [8i+7:8i]
//     in_key     in   cipher key, same packing
//     out_valid  out  ciphertext valid (held until out_ready)
//     out_ready  in   consumer accepts ciphertext
//     out_ct     out  ciphertext, same packing
//     out_key    out  round-10 key (zero when KEEP_KEY = 0)
module aes64_blk_seq
  import aes64_pkg::*;
#(
  parameter bit KEEP_KEY = 1'b1
) (
  input  logic         g_clk,
  input  logic         g_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic [127:0] out_key
);

  seq_state_t  state_q, state_d;
  logic [3:0]  rnd_q;
  logic [63:0] s0_q, s1_q, k0_q, k1_q, t_q, n0_q;

  logic        dp_valid, dp_ks1, dp_ks2, dp_enc, dp_hi, dp_mix;
  logic [63:0] dp_rs1, dp_rs2, dp_rd;
  logic        dp_ready_unused;

  dword_pair_t init_state;
  dword_pair_t init_key;

  assign init_state = split128(in_pt ^ in_key);
  assign init_key   = split128(in_key);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_ct    = (state_q == DONE) ? {s1_q, s0_q} : '0;

  aes64 u_aes64 (
    .valid   (dp_valid),
    .op_ks1  (dp_ks1),
    .op_ks2  (dp_ks2),
    .op_enc  (dp_enc),
    .op_dec  (1'b0),
    .op_imix (1'b0),
    .hi      (dp_hi),
    .mix     (dp_mix),
    .rs1     (dp_rs1),
    .rs2     (dp_rs2),
    .ready   (dp_ready_unused),
    .rd      (dp_rd)
  );

  always_comb begin
    state_d  = state_q;
    dp_valid = 1'b0;
    dp_ks1   = 1'b0;
    dp_ks2   = 1'b0;
    dp_enc   = 1'b0;
    dp_hi    = 1'b0;
    dp_mix   = (rnd_q != LAST_ROUND);
    dp_rs1   = '0;
    dp_rs2   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = KS1;
      end
      KS1: begin
        dp_valid = 1'b1;
        dp_ks1   = 1'b1;
        dp_rs1   = k1_q;
        dp_rs2   = {60'h0, rnd_q};
        state_d  = KS2A;
      end
      KS2A: begin
        dp_valid = 1'b1;
        dp_ks2   = 1'b1;
        dp_rs1   = t_q;
        dp_rs2   = k0_q;
        state_d  = KS2B;
      end
      // k0_q already holds the new low key half written in KS2A.
      KS2B: begin
        dp_valid = 1'b1;
        dp_ks2   = 1'b1;
        dp_rs1   = k0_q;
        dp_rs2   = k1_q;
        state_d  = ENC_LO;
      end
      ENC_LO: begin
        dp_valid = 1'b1;
        dp_enc   = 1'b1;
        dp_rs1   = s0_q;
        dp_rs2   = s1_q;
        state_d  = ENC_HI;
      end
      ENC_HI: begin
        dp_valid = 1'b1;
        dp_enc   = 1'b1;
        dp_hi    = 1'b1;
        dp_rs1   = s0_q;
        dp_rs2   = s1_q;
        state_d  = (rnd_q == LAST_ROUND) ? DONE : KS1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // s0 is only overwritten in ENC_HI (from n0) so both state halves of a
  // round are computed from the same pre-round state.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      t_q     <= '0;
      n0_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            s0_q  <= init_state.lo;
            s1_q  <= init_state.hi;
            k0_q  <= init_key.lo;
            k1_q  <= init_key.hi;
            rnd_q <= '0;
          end
        end
        KS1:    t_q  <= dp_rd;
        KS2A:   k0_q <= dp_rd;
        KS2B:   k1_q <= dp_rd;
        ENC_LO: n0_q <= dp_rd ^ k0_q;
        ENC_HI: begin
          s1_q <= dp_rd ^ k1_q;
          s0_q <= n0_q;
          if (rnd_q != LAST_ROUND) rnd_q <= rnd_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  generate
    if (KEEP_KEY) begin : g_keep_key
      logic [127:0] key_q;

      // The round-10 key is complete once KS2B of the last round has run.
      always_ff @(posedge g_clk) begin
        if (g_rst) begin
          key_q <= '0;
        end else if (state_q == ENC_HI && rnd_q == LAST_ROUND) begin
          key_q <= {k1_q, k0_q};
        end
      end

      assign out_key = key_q;
    end else begin : g_no_key
      assign out_key = '0;
    end
  endgenerate

endmodule

// File: tb/tb_aes64_blk_seq.sv
// tb_aes64_blk_seq
//   Self-checking bench for aes64_blk_seq. Two instances share all inputs:
//   dut keeps the final key, dut_nk is built with KEEP_KEY = 0. Expected
//   values come from FIPS-197 vectors and a byte-level AES-128 model.
module tb_aes64_blk_seq;

  logic         g_clk;
  logic         g_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic [127:0] out_key;

  logic         nk_in_ready;
  logic         nk_out_valid;
  logic [127:0] nk_out_ct;
  logic [127:0] nk_out_key;

  int checks;
  int failures;

  logic [7:0] sbox_t [256];

  aes64_blk_seq #(.KEEP_KEY(1'b1)) dut (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .out_key   (out_key)
  );

  aes64_blk_seq #(.KEEP_KEY(1'b0)) dut_nk (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .in_valid  (in_valid),
    .in_ready  (nk_in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (nk_out_valid),
    .out_ready (out_ready),
    .out_ct    (nk_out_ct),
    .out_key   (nk_out_key)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- reference model ----------------

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) + affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic void aes_ref(input logic [127:0] pt, input logic [127:0] key,
                                  output logic [127:0] ct, output logic [127:0] last_key);
    logic [7:0] w [44][4];
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] t4 [4];
    logic [7:0] r4 [4];
    logic [7:0] rc;
    logic [7:0] a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) w[i][b] = key[8*(4*i+b) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int b = 0; b < 4; b++) t4[b] = w[i-1][b];
      if (i % 4 == 0) begin
        for (int b = 0; b < 4; b++) r4[b] = sbox_t[t4[(b+1)%4]];
        for (int b = 0; b < 4; b++) t4[b] = r4[b];
        t4[0] = t4[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t4[b];
    end
    for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8] ^ w[i/4][i%4];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (r < 10) begin
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][i%4];
    end
    for (int i = 0; i < 16; i++) begin
      ct[8*i +: 8]       = st[i];
      last_key[8*i +: 8] = w[40 + i/4][i%4];
    end
  endfunction

  // FIPS-197 hex strings list byte 0 first; the bus puts byte 0 at [7:0].
  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------

  task automatic send_req(input logic [127:0] pt, input logic [127:0] key);
    @(negedge g_clk);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
  endtask

  // Returns the cycle (accept cycle = 0) in which out_valid is seen, or -1.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge g_clk);
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    g_rst = 1'b1;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    checks++;
    if ({in_ready, out_valid, out_ct, out_key} !== {1'b1, 1'b0, 128'h0, 128'h0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got in_ready=%b out_valid=%b out_ct=%h out_key=%h, want 1 0 0 0",
               in_ready, out_valid, out_ct, out_key);
    end
    checks++;
    if ({nk_in_ready, nk_out_valid, nk_out_key} !== {1'b1, 1'b0, 128'h0}) begin
      failures++;
      $display("[TB] FAIL reset_state_nk: got in_ready=%b out_valid=%b out_key=%h", nk_in_ready, nk_out_valid, nk_out_key);
    end
  endtask

  task automatic run_vector(input string name, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp_ct, input logic [127:0] exp_key);
    int cyc;
    send_req(pt, key);
    wait_out(cyc);
    checks++;
    if (cyc != 51) begin
      failures++;
      $display("[TB] FAIL %s_latency: out_valid at cycle %0d after accept, want 51", name, cyc);
    end
    checks++;
    if (out_ct !== exp_ct) begin
      failures++;
      $display("[TB] FAIL %s_ct: got %h want %h", name, out_ct, exp_ct);
    end
    checks++;
    if (out_key !== exp_key) begin
      failures++;
      $display("[TB] FAIL %s_key: got %h want %h", name, out_key, exp_key);
    end
    checks++;
    if ({nk_out_valid, nk_out_ct, nk_out_key} !== {1'b1, exp_ct, 128'h0}) begin
      failures++;
      $display("[TB] FAIL %s_nokey: got valid=%b ct=%h key=%h want 1 %h 0", name, nk_out_valid, nk_out_ct, nk_out_key, exp_ct);
    end
    consume();
  endtask

  task automatic test_fips();
    run_vector("fips_b", fips(128'h3243f6a8885a308d313198a2e0370734), fips(128'h2b7e151628aed2a6abf7158809cf4f3c),
               fips(128'h3925841d02dc09fbdc118597196a0b32), fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    run_vector("fips_c1", fips(128'h00112233445566778899aabbccddeeff), fips(128'h000102030405060708090a0b0c0d0e0f),
               fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a), fips(128'h13111d7fe3944a17f307a78b4d2b30c5));
  endtask

  task automatic test_random();
    logic [127:0] pt, key, ect, ekey;
    for (int n = 0; n < 6; n++) begin
      pt  = rand128();
      key = rand128();
      aes_ref(pt, key, ect, ekey);
      run_vector("random", pt, key, ect, ekey);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, key, ect, ekey;
    int cyc;
    pt  = rand128();
    key = rand128();
    aes_ref(pt, key, ect, ekey);
    send_req(pt, key);
    wait_out(cyc);
    checks++;
    if (cyc != 51) begin
      failures++;
      $display("[TB] FAIL bp_latency: out_valid at cycle %0d, want 51", cyc);
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({out_valid, in_ready, out_ct, out_key} !== {1'b1, 1'b0, ect, ekey}) begin
        failures++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b in_ready=%b ct=%h key=%h want 1 0 %h %h",
                 k, out_valid, in_ready, out_ct, out_key, ect, ekey);
      end
      @(negedge g_clk);
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_no_overlap: in_ready=%b in consume cycle, want 0", in_ready);
    end
    @(negedge g_clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_input();
    logic [127:0] pt_b, key_b, ct_b, key_out_b;
    logic         ready_seen;
    pt_b      = fips(128'h3243f6a8885a308d313198a2e0370734);
    key_b     = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ct_b      = fips(128'h3925841d02dc09fbdc118597196a0b32);
    key_out_b = fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ready_seen = 1'b0;
    send_req(pt_b, key_b);
    for (int c = 1; c <= 50; c++) begin
      in_valid  = 1'b1;
      in_pt     = rand128();
      in_key    = rand128();
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready) ready_seen = 1'b1;
      @(negedge g_clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ready_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_in_ready: in_ready=%b seen while busy, want 0", ready_seen);
    end
    checks++;
    if ({out_valid, out_ct, out_key} !== {1'b1, ct_b, key_out_b}) begin
      failures++;
      $display("[TB] FAIL busy_result: got valid=%b ct=%h key=%h want 1 %h %h", out_valid, out_ct, out_key, ct_b, key_out_b);
    end
    consume();
    run_vector("b2b_c1", fips(128'h00112233445566778899aabbccddeeff), fips(128'h000102030405060708090a0b0c0d0e0f),
               fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a), fips(128'h13111d7fe3944a17f307a78b4d2b30c5));
  endtask

  task automatic test_reset_midop();
    send_req(rand128(), rand128());
    repeat (24) @(negedge g_clk);
    g_rst = 1'b1;
    @(negedge g_clk);
    g_rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_ct} !== {1'b1, 1'b0, 128'h0}) begin
      failures++;
      $display("[TB] FAIL midop_reset: got in_ready=%b out_valid=%b out_ct=%h want 1 0 0", in_ready, out_valid, out_ct);
    end
    run_vector("after_rst_c1", fips(128'h00112233445566778899aabbccddeeff), fips(128'h000102030405060708090a0b0c0d0e0f),
               fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a), fips(128'h13111d7fe3944a17f307a78b4d2b30c5));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    g_rst     = 1'b1;
    in_valid  = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    out_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_busy_input();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
